serial_adder_ctrl: RTL

Bit-serial add/subtract sequencer that time-shares one 1-bit FullAdder cell across a WIDTH-bit operation, LSB first, one bit per clock. It accepts operands on a start/ready handshake and pulses done with sum, carry and signed overflow. It serves as the area-minimal arithmetic engine beside the parallel ALU, for low-rate address and counter updates.

---
 rtl/serial_adder_pkg.sv | 35 +++
 rtl/FullAdder.sv | 22 ++
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial add/subtract sequencer:
//               FSM state encoding and a constant clog2 helper used to size
//               the bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Number of bits needed to count 0..value-1 (value >= 2 gives >= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// ============================================================================
// Module      : FullAdder
// Description : One-bit full adder; the bit-slice datapath of the serial
//               adder.
// Ports       : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : FullAdder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract sequencer. One FullAdder cell is
//               time-shared over WIDTH bits, LSB first, one bit per clock.
//               Operands are taken on start while ready; done pulses for one
//               cycle with sum, cout and signed overflow.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               start, sub, a, b   - request, operation select, operands
//               ready, busy, done  - handshake / status
//               sum, cout, overflow- registered result, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int              CW         = clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_PENULT = CW'(WIDTH - 2);

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic             cmsb;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             finish;

  logic             fa_sum;
  logic             fa_cout;

  FullAdder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and control decode.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      shreg    <= '0;
      carry    <= 1'b0;
      cmsb     <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        // Subtraction is a + ~b + 1: invert B up front and seed the carry.
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (step) begin
        shreg <= {fa_sum, shreg[WIDTH-1:1]};
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        carry <= fa_cout;
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt == CNT_PENULT) begin
          cmsb <= fa_cout;
        end
        if (finish) begin
          sum      <= {fa_sum, shreg[WIDTH-1:1]};
          cout     <= fa_cout;
          overflow <= cmsb ^ fa_cout;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule : serial_adder_ctrl
`default_nettype wire
